// File: rtl/btc_pkg.sv
// Shared types and constants for the bitcoin job dispatcher.
// BTC_JOB_PRELOAD_EN (in btc_job_dispatcher) adds a shadow header buffer.
package btc_pkg;

    localparam int HDR_WORDS = 20;

    localparam logic [4:0] IDX_VERSION = 5'd0;
    localparam logic [4:0] IDX_PREV    = 5'd1;
    localparam logic [4:0] IDX_MERKLE  = 5'd9;
    localparam logic [4:0] IDX_BTIME   = 5'd17;
    localparam logic [4:0] IDX_BITS    = 5'd18;
    localparam logic [4:0] IDX_NONCE   = 5'd19;

    localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        LOAD,
        START,
        ARM,
        MINE,
        RESULT
    } state_e;

    typedef logic [HDR_WORDS-1:0][31:0] hdr_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CYC_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/btc_hdr_regs.sv
// 20x32 block-header register file: single indexed write port,
// whole-file parallel load, all words visible on rdata.
module btc_hdr_regs
    import btc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        ld,
    input  hdr_t        ld_data,
    output hdr_t        rdata
);

    hdr_t words_q;
    hdr_t words_d;

    always_comb begin
        words_d = words_q;
        if (ld) begin
            words_d = ld_data;
        end else if (we && (waddr <= IDX_NONCE)) begin
            words_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign rdata = words_q;

endmodule

// File: rtl/btc_job_dispatcher.sv
// Loads a 20-word block header, starts the miner, returns the result.
// Define BTC_JOB_PRELOAD_EN to accept the next job while mining.
module btc_job_dispatcher
    import btc_pkg::*;
#(
    parameter logic USE_NONCE_IN = 1'b1,
    parameter logic ONESHOT      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_found,
    output logic [31:0] res_nonce,
    output logic [31:0] res_cycles,
    output logic        miner_start,
    output logic        miner_use_nonce_in,
    output logic        miner_oneshot,
    output logic [31:0] miner_version,
    output logic [31:0] miner_previous_hash_0,
    output logic [31:0] miner_previous_hash_1,
    output logic [31:0] miner_previous_hash_2,
    output logic [31:0] miner_previous_hash_3,
    output logic [31:0] miner_previous_hash_4,
    output logic [31:0] miner_previous_hash_5,
    output logic [31:0] miner_previous_hash_6,
    output logic [31:0] miner_previous_hash_7,
    output logic [31:0] miner_merkle_root_0,
    output logic [31:0] miner_merkle_root_1,
    output logic [31:0] miner_merkle_root_2,
    output logic [31:0] miner_merkle_root_3,
    output logic [31:0] miner_merkle_root_4,
    output logic [31:0] miner_merkle_root_5,
    output logic [31:0] miner_merkle_root_6,
    output logic [31:0] miner_merkle_root_7,
    output logic [31:0] miner_btime,
    output logic [31:0] miner_bits,
    output logic [31:0] miner_nonce_in,
    input  logic        miner_done,
    input  logic        miner_nonce_found_flag,
    input  logic [31:0] miner_nonce_out
);

    state_e      state_q, state_d;
    logic [4:0]  wcnt_q, wcnt_d;
    logic [31:0] cyc_q, cyc_d;
    logic        res_found_q, res_found_d;
    logic [31:0] res_nonce_q, res_nonce_d;
    logic [31:0] res_cycles_q, res_cycles_d;

    logic        hdr_we;
    hdr_t        hdr;

`ifdef BTC_JOB_PRELOAD_EN
    logic        hdr_ld;
    logic        sh_we;
    hdr_t        sh_rdata;
    hdr_t        sh_merge;
    logic [4:0]  swcnt_q, swcnt_d, sh_cnt_nx;
    logic        sfull_q, sfull_d, sh_full_nx;

    // Outside LOAD, words stream into the shadow buffer until it is full.
    assign job_ready = !rst && ((state_q == LOAD) || !sfull_q);
    assign hdr_we    = job_valid && job_ready && (state_q == LOAD);
    assign sh_we     = job_valid && job_ready && (state_q != LOAD);

    // The copy sees a word landing in the shadow on the same edge.
    always_comb begin
        sh_cnt_nx  = swcnt_q;
        sh_full_nx = sfull_q;
        sh_merge   = sh_rdata;
        if (sh_we) begin
            sh_merge[swcnt_q] = job_data;
            if (swcnt_q == IDX_NONCE) begin
                sh_cnt_nx  = '0;
                sh_full_nx = 1'b1;
            end else begin
                sh_cnt_nx = swcnt_q + 5'd1;
            end
        end
    end

    assign swcnt_d = hdr_ld ? 5'd0 : sh_cnt_nx;
    assign sfull_d = hdr_ld ? 1'b0 : sh_full_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            swcnt_q <= '0;
            sfull_q <= 1'b0;
        end else begin
            swcnt_q <= swcnt_d;
            sfull_q <= sfull_d;
        end
    end

    btc_hdr_regs u_shadow (
        .clk     (clk),
        .rst     (rst),
        .we      (sh_we),
        .waddr   (swcnt_q),
        .wdata   (job_data),
        .ld      (1'b0),
        .ld_data ('0),
        .rdata   (sh_rdata)
    );

    btc_hdr_regs u_hdr (
        .clk     (clk),
        .rst     (rst),
        .we      (hdr_we),
        .waddr   (wcnt_q),
        .wdata   (job_data),
        .ld      (hdr_ld),
        .ld_data (sh_merge),
        .rdata   (hdr)
    );
`else
    assign job_ready = !rst && (state_q == LOAD);
    assign hdr_we    = job_valid && job_ready;

    btc_hdr_regs u_hdr (
        .clk     (clk),
        .rst     (rst),
        .we      (hdr_we),
        .waddr   (wcnt_q),
        .wdata   (job_data),
        .ld      (1'b0),
        .ld_data ('0),
        .rdata   (hdr)
    );
`endif

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        cyc_d        = cyc_q;
        res_found_d  = res_found_q;
        res_nonce_d  = res_nonce_q;
        res_cycles_d = res_cycles_q;
`ifdef BTC_JOB_PRELOAD_EN
        hdr_ld       = 1'b0;
`endif
        unique case (state_q)
            LOAD: begin
                if (hdr_we) begin
                    if (wcnt_q == IDX_NONCE) begin
                        wcnt_d  = '0;
                        state_d = START;
                    end else begin
                        wcnt_d = wcnt_q + 5'd1;
                    end
                end
            end
            START: begin
                cyc_d   = '0;
                state_d = ARM;
            end
            // A done left high by the previous job must drop first.
            ARM: begin
                cyc_d = sat_inc(cyc_q);
                if (!miner_done) begin
                    state_d = MINE;
                end
            end
            MINE: begin
                cyc_d = sat_inc(cyc_q);
                if (miner_done) begin
                    res_found_d  = miner_nonce_found_flag;
                    res_nonce_d  = miner_nonce_out;
                    res_cycles_d = sat_inc(cyc_q);
                    state_d      = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = LOAD;
`ifdef BTC_JOB_PRELOAD_EN
                    hdr_ld = 1'b1;
                    wcnt_d = sh_cnt_nx;
                    if (sh_full_nx) begin
                        state_d = START;
                    end
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wcnt_q       <= '0;
            cyc_q        <= '0;
            res_found_q  <= 1'b0;
            res_nonce_q  <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            cyc_q        <= cyc_d;
            res_found_q  <= res_found_d;
            res_nonce_q  <= res_nonce_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    assign miner_start = !rst && (state_q == START);
    assign res_valid   = !rst && (state_q == RESULT);
    assign res_found   = res_found_q;
    assign res_nonce   = res_nonce_q;
    assign res_cycles  = res_cycles_q;

    assign miner_use_nonce_in = USE_NONCE_IN;
    assign miner_oneshot      = ONESHOT;

    assign miner_version         = hdr[IDX_VERSION];
    assign miner_previous_hash_0 = hdr[IDX_PREV + 5'd0];
    assign miner_previous_hash_1 = hdr[IDX_PREV + 5'd1];
    assign miner_previous_hash_2 = hdr[IDX_PREV + 5'd2];
    assign miner_previous_hash_3 = hdr[IDX_PREV + 5'd3];
    assign miner_previous_hash_4 = hdr[IDX_PREV + 5'd4];
    assign miner_previous_hash_5 = hdr[IDX_PREV + 5'd5];
    assign miner_previous_hash_6 = hdr[IDX_PREV + 5'd6];
    assign miner_previous_hash_7 = hdr[IDX_PREV + 5'd7];
    assign miner_merkle_root_0   = hdr[IDX_MERKLE + 5'd0];
    assign miner_merkle_root_1   = hdr[IDX_MERKLE + 5'd1];
    assign miner_merkle_root_2   = hdr[IDX_MERKLE + 5'd2];
    assign miner_merkle_root_3   = hdr[IDX_MERKLE + 5'd3];
    assign miner_merkle_root_4   = hdr[IDX_MERKLE + 5'd4];
    assign miner_merkle_root_5   = hdr[IDX_MERKLE + 5'd5];
    assign miner_merkle_root_6   = hdr[IDX_MERKLE + 5'd6];
    assign miner_merkle_root_7   = hdr[IDX_MERKLE + 5'd7];
    assign miner_btime           = hdr[IDX_BTIME];
    assign miner_bits            = hdr[IDX_BITS];
    assign miner_nonce_in        = hdr[IDX_NONCE];

endmodule

// File: tb/tb_btc_job_dispatcher.sv
// Bench for btc_job_dispatcher: job table plus reset/saturation/preload
// sequences, with a result scoreboard drained by a negedge monitor.
module tb_btc_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_data;
    logic        res_valid;
    logic        res_ready;
    logic        res_found;
    logic [31:0] res_nonce;
    logic [31:0] res_cycles;
    logic        miner_start;
    logic        miner_use_nonce_in;
    logic        miner_oneshot;
    logic [31:0] hw [20];
    logic        miner_done;
    logic        miner_nonce_found_flag;
    logic [31:0] miner_nonce_out;

    always #5 clk = ~clk;

`ifdef BTC_JOB_PRELOAD_EN
    localparam logic BUSY_RDY = 1'b1;
`else
    localparam logic BUSY_RDY = 1'b0;
`endif

    btc_job_dispatcher dut (
        .clk                    (clk),
        .rst                    (rst),
        .job_valid              (job_valid),
        .job_ready              (job_ready),
        .job_data               (job_data),
        .res_valid              (res_valid),
        .res_ready              (res_ready),
        .res_found              (res_found),
        .res_nonce              (res_nonce),
        .res_cycles             (res_cycles),
        .miner_start            (miner_start),
        .miner_use_nonce_in     (miner_use_nonce_in),
        .miner_oneshot          (miner_oneshot),
        .miner_version          (hw[0]),
        .miner_previous_hash_0  (hw[1]),
        .miner_previous_hash_1  (hw[2]),
        .miner_previous_hash_2  (hw[3]),
        .miner_previous_hash_3  (hw[4]),
        .miner_previous_hash_4  (hw[5]),
        .miner_previous_hash_5  (hw[6]),
        .miner_previous_hash_6  (hw[7]),
        .miner_previous_hash_7  (hw[8]),
        .miner_merkle_root_0    (hw[9]),
        .miner_merkle_root_1    (hw[10]),
        .miner_merkle_root_2    (hw[11]),
        .miner_merkle_root_3    (hw[12]),
        .miner_merkle_root_4    (hw[13]),
        .miner_merkle_root_5    (hw[14]),
        .miner_merkle_root_6    (hw[15]),
        .miner_merkle_root_7    (hw[16]),
        .miner_btime            (hw[17]),
        .miner_bits             (hw[18]),
        .miner_nonce_in         (hw[19]),
        .miner_done             (miner_done),
        .miner_nonce_found_flag (miner_nonce_found_flag),
        .miner_nonce_out        (miner_nonce_out)
    );

    typedef struct {
        logic [31:0] base;
        int          gap;
        int          stale;
        int          low;
        logic        found;
        logic [31:0] nonce;
        logic [31:0] exp_cyc;
        int          hold;
        bit          sat;
    } vec_t;

    typedef struct packed {
        logic        found;
        logic [31:0] nonce;
        logic [31:0] cyc;
    } res_t;

    localparam int NV = 5;
    vec_t vecs [NV];
    res_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h expected=none",
                         res_nonce);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("res_found", {31'd0, res_found}, {31'd0, e.found});
                chk("res_nonce", res_nonce, e.nonce);
                chk("res_cycles", res_cycles, e.cyc);
            end
        end
    end

    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        job_valid = 1'b1;
        job_data  = d;
        @(negedge clk);
        while (!job_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) begin
            chk("send_timeout", {31'd0, job_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    task automatic chk_hdr(input logic [31:0] base);
        for (int w = 0; w < 20; w++) begin
            chk($sformatf("hdr%0d", w), hw[w], base + 32'(w));
        end
    endtask

    task automatic run_job(input vec_t v);
        res_t e;
        for (int w = 0; w < 20; w++) begin
            send_word(v.base + 32'(w));
            if (v.gap > 0 && w < 19) begin
                repeat (v.gap) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("start_on", {31'd0, miner_start}, 32'd1);
        chk_hdr(v.base);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("start_off", {31'd0, miner_start}, 32'd0);
        repeat (v.stale) @(posedge clk);
        #1;
        miner_done = 1'b0;
        if (v.sat) force dut.cyc_q = 32'hFFFF_FFFF;
        repeat (v.low) @(posedge clk);
        #1;
        miner_done             = 1'b1;
        miner_nonce_found_flag = v.found;
        miner_nonce_out        = v.nonce;
        e = '{found: v.found, nonce: v.nonce, cyc: v.exp_cyc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (v.sat) release dut.cyc_q;
        repeat (v.hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_nonce", res_nonce, v.nonce);
            chk("hold_cycles", res_cycles, v.exp_cyc);
            chk("hold_rdy", {31'd0, job_ready}, {31'd0, BUSY_RDY});
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("load_rdy", {31'd0, job_ready}, 32'd1);
        chk("load_valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic abort_mid_job();
        for (int w = 0; w < 7; w++) begin
            send_word(32'hBAD0_0000 + 32'(w));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdy", {31'd0, job_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hdr0", hw[0], 32'd0);
        chk("rst_hdr6", hw[6], 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 0, 0, 5, 1'b1, 32'h1234_5678,
                    32'd6, 10, 1'b0};
        vecs[1] = '{32'h0000_0100, 1, 3, 1, 1'b0, 32'h0000_0000,
                    32'd5, 0, 1'b0};
        vecs[2] = '{32'hA000_0000, 0, 1, 1, 1'b1, 32'hDEAD_BEEF,
                    32'd3, 2, 1'b0};
        vecs[3] = '{32'h0000_5500, 2, 0, 12, 1'b0, 32'hFFFF_FFFF,
                    32'd13, 1, 1'b0};
        vecs[4] = '{32'h0000_7700, 0, 0, 3, 1'b1, 32'hCAFE_F00D,
                    32'hFFFF_FFFF, 0, 1'b1};

        rst                    = 1'b1;
        job_valid              = 1'b0;
        job_data               = '0;
        res_ready              = 1'b0;
        miner_done             = 1'b1;
        miner_nonce_found_flag = 1'b0;
        miner_nonce_out        = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_job_ready", {31'd0, job_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_start", {31'd0, miner_start}, 32'd0);
        chk("rst_res_cycles", res_cycles, 32'd0);
        chk("rst_res_nonce", res_nonce, 32'd0);
        chk("rst_version", hw[0], 32'd0);
        chk("rst_nonce_in", hw[19], 32'd0);
        chk("cfg_use_nonce", {31'd0, miner_use_nonce_in}, 32'd1);
        chk("cfg_oneshot", {31'd0, miner_oneshot}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {31'd0, job_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            if (i == 1) abort_mid_job();
            run_job(vecs[i]);
        end

`ifdef BTC_JOB_PRELOAD_EN
        begin
            res_t e;
            for (int w = 0; w < 20; w++) send_word(32'h0000_1000 + 32'(w));
            @(negedge clk);
            chk("pre_a_start", {31'd0, miner_start}, 32'd1);
            @(posedge clk);
            #1;
            miner_done = 1'b0;
            @(posedge clk);
            #1;
            for (int w = 0; w < 20; w++) send_word(32'h0000_2000 + 32'(w));
            @(negedge clk);
            chk("pre_full_rdy", {31'd0, job_ready}, 32'd0);
            chk("pre_a_hdr", hw[19], 32'h0000_1013);
            miner_done             = 1'b1;
            miner_nonce_found_flag = 1'b1;
            miner_nonce_out        = 32'hABCD_0001;
            e = '{found: 1'b1, nonce: 32'hABCD_0001, cyc: 32'd22};
            sb.push_back(e);
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            @(negedge clk);
            chk("pre_b_start", {31'd0, miner_start}, 32'd1);
            chk_hdr(32'h0000_2000);
            @(posedge clk);
            #1;
            miner_done = 1'b0;
            @(posedge clk);
            #1;
            miner_done             = 1'b1;
            miner_nonce_found_flag = 1'b0;
            miner_nonce_out        = 32'h0000_BBBB;
            e = '{found: 1'b0, nonce: 32'h0000_BBBB, cyc: 32'd2};
            sb.push_back(e);
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            @(negedge clk);
            chk("pre_b_load", {31'd0, job_ready}, 32'd1);
        end
`endif

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btc_job_dispatcher.md
BTC_JOB_DISPATCHER -- requirements
Module: btc_job_dispatcher

Interface
REQ-001 Parameter USE_NONCE_IN, default 1'b1: value driven on miner_use_nonce_in.
REQ-002 Parameter ONESHOT, default 1'b0: value driven on miner_oneshot.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 job_valid / job_ready  in / out  1 / 1  header word handshake; a transfer occurs when both are high on a clock edge.
REQ-006 job_data  in  32  header word.
REQ-007 res_valid / res_ready  out / in  1 / 1  result handshake; a transfer occurs when both are high on a clock edge.
REQ-008 res_found  out  1  miner nonce_found_flag for the job.
REQ-009 res_nonce  out  32  miner nonce_out for the job.
REQ-010 res_cycles  out  32  clocks from miner_start to done.
REQ-011 miner_start  out  1  single-cycle start pulse.
REQ-012 miner_use_nonce_in, miner_oneshot  out  1 each  miner configuration.
REQ-013 miner_version, miner_previous_hash_0..7, miner_merkle_root_0..7, miner_btime, miner_bits, miner_nonce_in  out  32 each  header fields.
REQ-014 miner_done, miner_nonce_found_flag  in  1 each; miner_nonce_out  in  32.

Function
REQ-015 A job SHALL be exactly 20 words in this order: 0 version, 1-8 previous_hash_0..7, 9-16 merkle_root_0..7, 17 btime, 18 bits, 19 nonce_in.
REQ-016 The FSM SHALL have the states LOAD, START, ARM, MINE and RESULT.
REQ-017 LOAD: job_ready=1; each transfer writes the word at index wcnt (0..19), then wcnt increments; a transfer at wcnt=19 SHALL reset wcnt to 0 and move the FSM to START.
REQ-018 START: miner_start=1 for exactly one cycle, the cycle counter clears to 0, and the FSM moves to ARM.
REQ-019 ARM: waits for miner_done=0, then moves to MINE; a done that stays high from the previous job SHALL NOT complete the new job.
REQ-020 MINE: when miner_done=1, the FSM SHALL capture res_found, res_nonce and res_cycles in that cycle, and move to RESULT.
REQ-021 RESULT: res_valid=1 with stable data until accepted; on transfer, the FSM moves to LOAD.
REQ-022 The cycle counter SHALL increment in every ARM and MINE cycle and saturate at 32'hFFFF_FFFF (no wrap).
REQ-023 Header outputs SHALL remain stable from START until the FSM leaves MINE.
REQ-024 job_valid=0 mid-job SHALL stall loading without losing wcnt.
REQ-025 Outside LOAD, job_ready=0, unless BTC_JOB_PRELOAD_EN is defined (see Configuration).

Reset
REQ-026 While rst=1: FSM=LOAD, wcnt=0, cycle counter=0, job_ready=0, res_valid=0, miner_start=0, res_* =0, and all header outputs =0.
REQ-027 rst asserted in any state SHALL abandon the job on the next edge; the partial header and the pending result are discarded.

Configuration
REQ-028 When BTC_JOB_PRELOAD_EN is defined, a second 20-word shadow buffer SHALL accept the next job while the FSM is in START, ARM, MINE or RESULT.
REQ-029 In that build, job_ready=1 until the shadow buffer is full; on the RESULT transfer, a full shadow buffer is copied to the header outputs and the FSM goes directly to START.
REQ-030 When BTC_JOB_PRELOAD_EN is undefined, the shadow buffer SHALL NOT exist and REQ-025 applies.

Structure
REQ-031 The package btc_pkg SHALL hold: the FSM state enum, HDR_WORDS=20, the word-index constants IDX_VERSION=0, IDX_PREV=1, IDX_MERKLE=9, IDX_BTIME=17, IDX_BITS=18, IDX_NONCE=19, and CYC_MAX=32'hFFFF_FFFF.
REQ-032 One sub-module, btc_hdr_regs, SHALL hold the 20×32 header register file with indexed write; it is instantiated twice when BTC_JOB_PRELOAD_EN is defined.

Verification
REQ-033 Load 20 words 0x00..0x13 with no gaps -> miner_version=0x00, miner_merkle_root_7=0x10, miner_nonce_in=0x13, and one miner_start pulse in the cycle after the 20th transfer.
REQ-034 Hold miner_done=1 through START, drop it for 5 cycles, then raise it with nonce_out=0x1234_5678 and found=1 -> res_valid=1, res_nonce=0x1234_5678, res_found=1, res_cycles=6.
REQ-035 Hold res_ready=0 for 10 cycles -> res_valid and the res_* data stay stable and job_ready=0; after res_ready=1 -> LOAD.
REQ-036 Assert rst at wcnt=7, then reload a full job -> its 20 words map from index 0, with no stale words.
REQ-037 Force miner_done=0 for 2^32+3 cycles (counter preloaded by force) -> res_cycles=32'hFFFF_FFFF.
REQ-038 Preload build: stream job B during job A's MINE state -> job_ready falls after B's 20th word; after the A result transfer, miner_start pulses in the next cycle with B's header.
